axi_ddr3_arbiter: RTL
=====================

AXI_DDR3_ARBITER -- requirements
Module: axi_ddr3_arbiter

Interface
REQ-001 SHALL have parameter ADDRS, default 27, AXI byte-address width.
REQ-002 SHALL have parameter SID, default 3, upstream ID width; downstream ID width is SID+1.
REQ-003 SHALL have parameter WIDTH, default 32, data width; strobe width WIDTH/8.
REQ-004 SHALL have parameter OUTSTANDING, default 4, maximum reads in flight per requester.
REQ-005 SHALL have port aclk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port bundles s0_* and s1_*, slave side: aw{valid,ready,addr,id,len,burst}, w{valid,ready,last,strb,data}, b{valid,ready,id,resp}, ar{valid,ready,addr,id,len,burst}, r{valid,ready,last,id,resp,data}.
REQ-008 SHALL have port bundle m_*, master side toward the DDR3 controller, with the same signals and IDs SID+1 wide.

Function
REQ-009 SHALL forward on m_ARID/m_AWID the value {grant, s_id}; grant is 0 for s0 and 1 for s1.
REQ-010 SHALL use a write FSM with states W_IDLE, W_ADDR and W_DATA.
REQ-011 SHALL in W_IDLE, when any s_awvalid is high, register the granted AW onto m_aw*, assert the granted s_awready for exactly one cycle, and go to W_ADDR.
REQ-012 SHALL in W_ADDR hold m_awvalid until m_awready, then go to W_DATA.
REQ-013 SHALL in W_DATA connect the granted s_w* to m_w* combinationally, hold the other s_wready low, and return to W_IDLE on a handshake with m_wlast=1.
REQ-014 SHALL keep both s_awready low outside W_IDLE, so only one write burst owns the W channel.
REQ-015 SHALL route B by m_bid[SID]: the matching s_bvalid follows m_bvalid, m_bready follows that s_bready, and s_bid is m_bid[SID-1:0].
REQ-016 SHALL use a read FSM with states R_IDLE and R_ADDR.
REQ-017 SHALL in R_IDLE grant an eligible s_arvalid, register it onto m_ar*, and pulse its s_arready for one cycle.
REQ-018 SHALL in R_ADDR hold m_arvalid until m_arready, then return to R_IDLE.
REQ-019 SHALL treat a requester as AR-eligible only while its in-flight count is less than OUTSTANDING.
REQ-020 SHALL increment the in-flight count on an m_ar handshake and decrement it on an r handshake with rlast=1.
REQ-021 SHALL leave the in-flight count unchanged when increment and decrement occur in the same cycle.
REQ-022 SHALL never let the in-flight count wrap past OUTSTANDING or below 0.
REQ-023 SHALL route R by m_rid[SID] in the same way as B.
REQ-024 SHALL use a separate round-robin pointer for AW and for AR.
REQ-025 SHALL grant the only requester when one is requesting; when both request, it SHALL grant the pointed requester.
REQ-026 SHALL set each pointer to the non-granted requester after every grant.
REQ-027 SHALL not let a requester's assertion of valid or withdrawal of an unaccepted valid alter an in-progress grant.
REQ-028 SHALL have a latency of one cycle from s_axvalid to m_axvalid in the idle state.

Reset
REQ-029 SHALL on aresetn low immediately drive m_awvalid, m_arvalid, m_wvalid, all s_awready/s_arready/s_wready and all s_bvalid/s_rvalid to 0.
REQ-030 SHALL on reset set the FSMs to W_IDLE and R_IDLE, the pointers to s0, and the in-flight counts to 0.
REQ-031 SHALL treat reset asserted mid-burst as an abandonment: no partial-burst recovery is required.

Verification
REQ-032 Both s_awvalid high at once, each with awlen=3 -> s0 is granted first with m_awid={1'b0,id}; 4 beats pass with m_wlast on beat 4; s1 is then granted with m_awid={1'b1,id}.
REQ-033 s1 issues 5 back-to-back ARs with rready=0 and OUTSTANDING=4 -> exactly 4 m_ar handshakes, the 5th s1_arready stays low, and s0 ARs are still granted.
REQ-034 m_rvalid with m_rid=4'b1010 -> s1_rvalid=1, s1_rid=3'b010, s0_rvalid=0, and m_rready equals s1_rready.
REQ-035 An R last-beat handshake and a new AR handshake for s0 in the same cycle -> s0 in-flight count is unchanged.
REQ-036 aresetn pulsed low during W_DATA -> all valid and ready outputs are 0 asynchronously, and after release the next AW grant goes to s0.
REQ-037 m_awready held low for 10 cycles -> m_awvalid and m_aw* stay stable, and no s_awready is asserted.

Source files
------------

// File: rtl/axi_ddr3_arbiter_if.sv
// AXI4 bundle shared by the two requester ports and the DDR3-side port.
// The ID width is a parameter so the downstream port can carry the extra grant bit.
interface axi_ddr3_arbiter_if #(
    parameter int ADDRS = 27,
    parameter int IDW   = 3,
    parameter int WIDTH = 32
);
    logic                 awvalid;
    logic                 awready;
    logic [ADDRS-1:0]     awaddr;
    logic [IDW-1:0]       awid;
    logic [7:0]           awlen;
    logic [1:0]           awburst;

    logic                 wvalid;
    logic                 wready;
    logic                 wlast;
    logic [WIDTH/8-1:0]   wstrb;
    logic [WIDTH-1:0]     wdata;

    logic                 bvalid;
    logic                 bready;
    logic [IDW-1:0]       bid;
    logic [1:0]           bresp;

    logic                 arvalid;
    logic                 arready;
    logic [ADDRS-1:0]     araddr;
    logic [IDW-1:0]       arid;
    logic [7:0]           arlen;
    logic [1:0]           arburst;

    logic                 rvalid;
    logic                 rready;
    logic                 rlast;
    logic [IDW-1:0]       rid;
    logic [1:0]           rresp;
    logic [WIDTH-1:0]     rdata;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wlast, wstrb, wdata,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rlast, rid, rresp, rdata,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wlast, wstrb, wdata,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rlast, rid, rresp, rdata,
        input  rready
    );
endinterface

// File: rtl/axi_ddr3_arbiter.sv
// Two-requester AXI4 arbiter in front of a DDR3 controller. Round-robin on AW and AR,
// one write burst owns the W channel at a time, reads are capped per requester.
module axi_ddr3_arbiter #(
    parameter int ADDRS       = 27,
    parameter int SID         = 3,
    parameter int WIDTH       = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_ddr3_arbiter_if.slave    s0,
    axi_ddr3_arbiter_if.slave    s1,
    axi_ddr3_arbiter_if.master   m
);
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
    typedef enum logic       {R_IDLE, R_ADDR}         r_state_t;

    w_state_t           r_w_state;
    logic               r_aw_ptr;
    logic               r_aw_gnt;
    logic [1:0]         r_s_awready;
    logic               r_awvalid;
    logic [ADDRS-1:0]   r_awaddr;
    logic [SID:0]       r_awid;
    logic [7:0]         r_awlen;
    logic [1:0]         r_awburst;

    r_state_t           r_r_state;
    logic               r_ar_ptr;
    logic               r_ar_gnt;
    logic [1:0]         r_s_arready;
    logic               r_arvalid;
    logic [ADDRS-1:0]   r_araddr;
    logic [SID:0]       r_arid;
    logic [7:0]         r_arlen;
    logic [1:0]         r_arburst;

    logic [1:0]         w_aw_req;
    logic               w_aw_pick;
    logic [1:0]         w_ar_elig;
    logic               w_ar_pick;
    logic               w_in_wdata;
    logic               w_ar_hs;
    logic               w_r_last_hs;
    logic [WIDTH-1:0]   w_wdata_sel;
    logic [WIDTH/8-1:0] w_wstrb_sel;

    // When both request, the pointer decides; otherwise the lone requester wins.
    assign w_aw_req  = {s1.awvalid, s0.awvalid};
    assign w_aw_pick = (w_aw_req == 2'b11) ? r_aw_ptr : w_aw_req[1];
    assign w_ar_pick = (w_ar_elig == 2'b11) ? r_ar_ptr : w_ar_elig[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_state   <= W_IDLE;
            r_aw_ptr    <= 1'b0;
            r_aw_gnt    <= 1'b0;
            r_s_awready <= 2'b00;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_awid      <= '0;
            r_awlen     <= '0;
            r_awburst   <= '0;
        end else begin
            r_s_awready <= 2'b00;
            case (r_w_state)
                W_IDLE: begin
                    if (|w_aw_req) begin
                        r_aw_gnt               <= w_aw_pick;
                        r_aw_ptr               <= ~w_aw_pick;
                        r_s_awready[w_aw_pick] <= 1'b1;
                        r_awvalid              <= 1'b1;
                        r_awaddr               <= w_aw_pick ? s1.awaddr  : s0.awaddr;
                        r_awid                 <= {w_aw_pick, (w_aw_pick ? s1.awid : s0.awid)};
                        r_awlen                <= w_aw_pick ? s1.awlen   : s0.awlen;
                        r_awburst              <= w_aw_pick ? s1.awburst : s0.awburst;
                        r_w_state              <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (m.awready) begin
                        r_awvalid <= 1'b0;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (m.wvalid && m.wready && m.wlast) begin
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    assign m.awvalid  = r_awvalid;
    assign m.awaddr   = r_awaddr;
    assign m.awid     = r_awid;
    assign m.awlen    = r_awlen;
    assign m.awburst  = r_awburst;
    assign s0.awready = r_s_awready[0];
    assign s1.awready = r_s_awready[1];

    // W is a straight combinational path from the owner of the current burst.
    assign w_in_wdata  = (r_w_state == W_DATA);
    assign w_wdata_sel = r_aw_gnt ? s1.wdata : s0.wdata;
    assign w_wstrb_sel = r_aw_gnt ? s1.wstrb : s0.wstrb;
    assign m.wvalid    = w_in_wdata & (r_aw_gnt ? s1.wvalid : s0.wvalid);
    assign m.wlast     = r_aw_gnt ? s1.wlast : s0.wlast;
    assign m.wdata     = w_wdata_sel;
    assign m.wstrb     = w_wstrb_sel;
    assign s0.wready   = w_in_wdata & ~r_aw_gnt & m.wready;
    assign s1.wready   = w_in_wdata &  r_aw_gnt & m.wready;

    // Responses are steered by the grant bit carried in the ID's top position.
    assign s0.bvalid = aresetn & m.bvalid & ~m.bid[SID];
    assign s1.bvalid = aresetn & m.bvalid &  m.bid[SID];
    assign m.bready  = m.bid[SID] ? s1.bready : s0.bready;
    assign s0.bid    = m.bid[SID-1:0];
    assign s1.bid    = m.bid[SID-1:0];
    assign s0.bresp  = m.bresp;
    assign s1.bresp  = m.bresp;

    assign s0.rvalid = aresetn & m.rvalid & ~m.rid[SID];
    assign s1.rvalid = aresetn & m.rvalid &  m.rid[SID];
    assign m.rready  = m.rid[SID] ? s1.rready : s0.rready;
    assign s0.rid    = m.rid[SID-1:0];
    assign s1.rid    = m.rid[SID-1:0];
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s1.rlast  = m.rlast;
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;

    assign w_ar_hs     = m.arvalid & m.arready;
    assign w_r_last_hs = m.rvalid & m.rready & m.rlast;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CW-1:0] r_inflight;
            logic          w_inc;
            logic          w_dec;
            logic          w_req;

            assign w_req = (gi == 0) ? s0.arvalid : s1.arvalid;
            assign w_inc = w_ar_hs && (r_ar_gnt == 1'(gi));
            assign w_dec = w_r_last_hs && (m.rid[SID] == 1'(gi));
            assign w_ar_elig[gi] = w_req && (r_inflight < CW'(OUTSTANDING));

            // A simultaneous issue and retire cancel out; both directions saturate.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_inflight <= '0;
                end else if (w_inc && !w_dec) begin
                    if (r_inflight < CW'(OUTSTANDING)) r_inflight <= r_inflight + CW'(1);
                end else if (w_dec && !w_inc) begin
                    if (r_inflight != '0) r_inflight <= r_inflight - CW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_r_state   <= R_IDLE;
            r_ar_ptr    <= 1'b0;
            r_ar_gnt    <= 1'b0;
            r_s_arready <= 2'b00;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arid      <= '0;
            r_arlen     <= '0;
            r_arburst   <= '0;
        end else begin
            r_s_arready <= 2'b00;
            case (r_r_state)
                R_IDLE: begin
                    if (|w_ar_elig) begin
                        r_ar_gnt               <= w_ar_pick;
                        r_ar_ptr               <= ~w_ar_pick;
                        r_s_arready[w_ar_pick] <= 1'b1;
                        r_arvalid              <= 1'b1;
                        r_araddr               <= w_ar_pick ? s1.araddr  : s0.araddr;
                        r_arid                 <= {w_ar_pick, (w_ar_pick ? s1.arid : s0.arid)};
                        r_arlen                <= w_ar_pick ? s1.arlen   : s0.arlen;
                        r_arburst              <= w_ar_pick ? s1.arburst : s0.arburst;
                        r_r_state              <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m.arready) begin
                        r_arvalid <= 1'b0;
                        r_r_state <= R_IDLE;
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign m.arvalid  = r_arvalid;
    assign m.araddr   = r_araddr;
    assign m.arid     = r_arid;
    assign m.arlen    = r_arlen;
    assign m.arburst  = r_arburst;
    assign s0.arready = r_s_arready[0];
    assign s1.arready = r_s_arready[1];
endmodule
